// File: rtl/sram_dp_be_pkg.sv
// sram_pkg: shared types and helpers for the dual-port SRAM.
// Holds the clear FSM state enum, lane width and even parity.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } st_e;

  localparam int LANE_W = 8;

  function automatic logic even_par(
    input logic [LANE_W-1:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// sram_dp_be_if: request/response bundle of the dual-port SRAM.
// Ports: init_req, ready, wr_en/addr/data/be, rd_en/addr,
// rd_data, rd_valid; par_inj/par_err under SRAM_PARITY_EN.
interface sram_dp_be_if #(
  parameter int ADDR = 4,
  parameter int DAT  = 32,
  parameter int BE_W = DAT / 8
) ();

  logic            init_req;
  logic            ready;
  logic            wr_en;
  logic [ADDR-1:0] wr_addr;
  logic [DAT-1:0]  wr_data;
  logic [BE_W-1:0] wr_be;
  logic            rd_en;
  logic [ADDR-1:0] rd_addr;
  logic [DAT-1:0]  rd_data;
  logic            rd_valid;
`ifdef SRAM_PARITY_EN
  logic            par_inj;
  logic            par_err;
`endif

  modport master (
    output init_req,
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_be,
    output rd_en,
    output rd_addr,
`ifdef SRAM_PARITY_EN
    output par_inj,
    input  par_err,
`endif
    input  ready,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  init_req,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    input  rd_en,
    input  rd_addr,
`ifdef SRAM_PARITY_EN
    input  par_inj,
    output par_err,
`endif
    output ready,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/sram_dp_be_array.sv
// sram_dp_array: lane-split storage, one write and one read port.
// Ports: clk, rst, we_i/waddr_i/wdata_i/wbe_i, re_i/raddr_i, rdata_o.
module sram_dp_array #(
  parameter int AW    = 4,
  parameter int DEPTH = 16,
  parameter int LANES = 4,
  parameter int LW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [LANES*LW-1:0] wdata_i,
  input  logic [LANES-1:0]    wbe_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [LANES*LW-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  assign widx = waddr_i[IW-1:0];
  assign ridx = raddr_i[IW-1:0];

  // One array per lane keeps the byte write a plain
  // whole-word write for each lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LW-1:0] mem_q [DEPTH];
    logic [LW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && wbe_i[l]) begin
        mem_q[widx] <= wdata_i[l*LW +: LW];
      end
    end

    // Read-first: sees the pre-write word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else if (re_i) begin
        rd_q <= mem_q[ridx];
      end
    end

    assign rdata_o[l*LW +: LW] = rd_q;
  end

endmodule

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple dual-port SRAM, byte enables, clear sweep,
// RD_LAT 1/2. Ports: clk, rst, bus (sram_dp_be_if.slave).
// Optional even parity per lane: define SRAM_PARITY_EN.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int ADDR   = 4,
  parameter int DAT    = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  sram_dp_be_if.slave  bus
);

  localparam int BE_W = DAT / LANE_W;
`ifdef SRAM_PARITY_EN
  localparam int LW = LANE_W + 1;
`else
  localparam int LW = LANE_W;
`endif
  localparam int SW = BE_W * LW;

  localparam logic [ADDR:0] DEPTH_L =
    (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST =
    ADDR'(DEPTH - 1);

  if (DAT % LANE_W != 0) begin : g_bad_dat
    $error("DAT must be a multiple of 8");
  end
  if (DEPTH > 2**ADDR) begin : g_bad_depth
    $error("DEPTH exceeds 2**ADDR");
  end

  st_e             state_q;
  st_e             state_d;
  logic [ADDR-1:0] clr_q;
  logic [ADDR-1:0] clr_d;
  logic            ready;

  logic            wr_in;
  logic            rd_in;
  logic            wr_ok;
  logic            rd_acc;

  logic            arr_we;
  logic [ADDR-1:0] arr_waddr;
  logic [SW-1:0]   arr_wdata;
  logic [BE_W-1:0] arr_wbe;
  logic [SW-1:0]   wr_st;
  logic [SW-1:0]   arr_rdata;

  logic            v1_q;
  logic            oor_q;
  logic [DAT-1:0]  s1_data;
`ifdef SRAM_PARITY_EN
  logic            s1_perr;
`endif

  // Clear FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST) begin
          state_d = ST_RUN;
          clr_d   = '0;
        end
        if (bus.init_req) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end
      end
      ST_RUN: begin
        if (bus.init_req) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  assign ready     = (state_q == ST_RUN);
  assign bus.ready = ready;

  // Request gating
  assign wr_in  = {1'b0, bus.wr_addr} < DEPTH_L;
  assign rd_in  = {1'b0, bus.rd_addr} < DEPTH_L;
  assign wr_ok  = bus.wr_en & ready & wr_in;
  assign rd_acc = bus.rd_en & ready;

  // Pack write data into storage lanes
  always_comb begin
    wr_st = '0;
    for (int l = 0; l < BE_W; l++) begin
      wr_st[l*LW +: LANE_W] =
        bus.wr_data[l*LANE_W +: LANE_W];
`ifdef SRAM_PARITY_EN
      wr_st[l*LW + LANE_W] =
        even_par(bus.wr_data[l*LANE_W +: LANE_W])
        ^ bus.par_inj;
`endif
    end
  end

  // Sweep owns the write port while clearing;
  // zero data carries zero parity.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = bus.wr_addr;
    arr_wdata = wr_st;
    arr_wbe   = bus.wr_be;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        arr_we    = 1'b1;
        arr_waddr = clr_q;
        arr_wdata = '0;
        arr_wbe   = '1;
      end
      wr_ok: begin
        arr_we = 1'b1;
      end
      default: begin
        arr_we = 1'b0;
      end
    endcase
  end

  sram_dp_array #(
    .AW    (ADDR),
    .DEPTH (DEPTH),
    .LANES (BE_W),
    .LW    (LW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .wbe_i   (arr_wbe),
    .re_i    (rd_acc & rd_in),
    .raddr_i (bus.rd_addr),
    .rdata_o (arr_rdata)
  );

  // Stage 1: valid and out-of-range flag.
  // oor_q only moves on accepted reads so
  // rd_data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        oor_q <= ~rd_in;
      end
    end
  end

  always_comb begin
    s1_data = '0;
    for (int l = 0; l < BE_W; l++) begin
      s1_data[l*LANE_W +: LANE_W] = oor_q ?
        '0 : arr_rdata[l*LW +: LANE_W];
    end
  end

`ifdef SRAM_PARITY_EN
  always_comb begin
    s1_perr = 1'b0;
    for (int l = 0; l < BE_W; l++) begin
      s1_perr = s1_perr |
        (arr_rdata[l*LW + LANE_W] ^
         even_par(arr_rdata[l*LW +: LANE_W]));
    end
    s1_perr = s1_perr & ~oor_q;
  end
`endif

  if (RD_LAT == 1) begin : g_lat1
    assign bus.rd_valid = v1_q;
    assign bus.rd_data  = s1_data;
`ifdef SRAM_PARITY_EN
    assign bus.par_err  = v1_q & s1_perr;
`endif
  end else if (RD_LAT == 2) begin : g_lat2
    logic           v2_q;
    logic [DAT-1:0] d2_q;
`ifdef SRAM_PARITY_EN
    logic           pe2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q  <= 1'b0;
        d2_q  <= '0;
`ifdef SRAM_PARITY_EN
        pe2_q <= 1'b0;
`endif
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= s1_data;
        end
`ifdef SRAM_PARITY_EN
        pe2_q <= v1_q & s1_perr;
`endif
      end
    end

    assign bus.rd_valid = v2_q;
    assign bus.rd_data  = d2_q;
`ifdef SRAM_PARITY_EN
    assign bus.par_err  = pe2_q;
`endif
  end else begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: directed checks of sram_dp_be.
// u1 RD_LAT=1, u2 RD_LAT=2, u3 DEPTH=12; shared stimulus.
module tb_sram_dp_be;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  always #5 clk = ~clk;

  sram_dp_be_if #(.ADDR(4), .DAT(32)) b1 ();
  sram_dp_be_if #(.ADDR(4), .DAT(32)) b2 ();
  sram_dp_be_if #(.ADDR(4), .DAT(32)) b3 ();

  assign b2.init_req = b1.init_req;
  assign b2.wr_en    = b1.wr_en;
  assign b2.wr_addr  = b1.wr_addr;
  assign b2.wr_data  = b1.wr_data;
  assign b2.wr_be    = b1.wr_be;
  assign b2.rd_en    = b1.rd_en;
  assign b2.rd_addr  = b1.rd_addr;
  assign b3.init_req = b1.init_req;
  assign b3.wr_en    = b1.wr_en;
  assign b3.wr_addr  = b1.wr_addr;
  assign b3.wr_data  = b1.wr_data;
  assign b3.wr_be    = b1.wr_be;
  assign b3.rd_en    = b1.rd_en;
  assign b3.rd_addr  = b1.rd_addr;
`ifdef SRAM_PARITY_EN
  assign b2.par_inj  = b1.par_inj;
  assign b3.par_inj  = b1.par_inj;
`endif

  sram_dp_be #(
    .ADDR(4), .DAT(32), .DEPTH(16), .RD_LAT(1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  sram_dp_be #(
    .ADDR(4), .DAT(32), .DEPTH(16), .RD_LAT(2)
  ) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  sram_dp_be #(
    .ADDR(4), .DAT(32), .DEPTH(12), .RD_LAT(1)
  ) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [3:0]  a,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    b1.wr_en   = 1'b1;
    b1.wr_addr = a;
    b1.wr_data = d;
    b1.wr_be   = be;
    tick();
    b1.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    b1.rd_en   = 1'b1;
    b1.rd_addr = a;
    tick();
    b1.rd_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    b1.init_req = 1'b0;
    b1.wr_en    = 1'b0;
    b1.wr_addr  = '0;
    b1.wr_data  = '0;
    b1.wr_be    = '0;
    b1.rd_en    = 1'b0;
    b1.rd_addr  = '0;
`ifdef SRAM_PARITY_EN
    b1.par_inj  = 1'b0;
`endif
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(b1.ready), 0);
    chk("rst_valid", 64'(b1.rd_valid), 0);
    chk("rst_data", 64'(b1.rd_data), 0);
    chk("rst_valid2", 64'(b2.rd_valid), 0);

    // Clear sweep after reset release
    rst = 1'b0;
    cnt = 0;
    while (!b1.ready && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("clr_cycles", 64'(cnt), 16);
    chk("u3_ready", 64'(b3.ready), 1);

    for (int i = 0; i < 16; i++) begin
      b1.rd_en   = 1'b1;
      b1.rd_addr = 4'(i);
      tick();
      chk("rd_zero",
          {b1.rd_valid, b1.rd_data},
          {1'b1, 32'h0});
    end
    b1.rd_en = 1'b0;
    tick();
    chk("rd_idle", 64'(b1.rd_valid), 0);

    // Byte enables
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    chk("be_merge",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'hAA22CC44});

    // Same-address read and write: read-first
    b1.wr_en   = 1'b1;
    b1.wr_addr = 4'd5;
    b1.wr_data = 32'h12345678;
    b1.wr_be   = 4'hF;
    b1.rd_en   = 1'b1;
    b1.rd_addr = 4'd5;
    tick();
    b1.wr_en   = 1'b0;
    chk("raw_old",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'h0});
    tick();
    b1.rd_en   = 1'b0;
    chk("raw_new",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'h12345678});

    // wr_be = 0 leaves the word alone
    wr(4'd3, 32'hFFFFFFFF, 4'h0);
    rd(4'd3);
    chk("be_none", 64'(b1.rd_data),
        64'h0AA22CC44);

    // Different addresses in one cycle
    b1.wr_en   = 1'b1;
    b1.wr_addr = 4'd6;
    b1.wr_data = 32'h0BADF00D;
    b1.wr_be   = 4'hF;
    b1.rd_en   = 1'b1;
    b1.rd_addr = 4'd3;
    tick();
    b1.wr_en   = 1'b0;
    b1.rd_en   = 1'b0;
    chk("indep_rd", 64'(b1.rd_data),
        64'h0AA22CC44);
    rd(4'd6);
    chk("indep_wr", 64'(b1.rd_data),
        64'h00BADF00D);

    // Out of range on the DEPTH=12 instance
    wr(4'd13, 32'hDEADBEEF, 4'hF);
    rd(4'd13);
    chk("oor_u1",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'hDEADBEEF});
    chk("oor_u3",
        {b3.rd_valid, b3.rd_data},
        {1'b1, 32'h0});

    // RD_LAT=2 streaming
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 32'(2 * i), 4'hF);
    end
    b1.rd_en   = 1'b1;
    b1.rd_addr = 4'd0;
    tick();
    chk("lat2_first", 64'(b2.rd_valid), 0);
    for (int i = 1; i <= 16; i++) begin
      b1.rd_en   = (i < 16);
      b1.rd_addr = 4'(i);
      tick();
      chk("lat2_seq",
          {b2.rd_valid, b2.rd_data},
          {1'b1, 32'(2 * (i - 1))});
    end
    tick();
    chk("lat2_end", 64'(b2.rd_valid), 0);

    // init_req with a read in flight
    b1.rd_en    = 1'b1;
    b1.rd_addr  = 4'd7;
    b1.init_req = 1'b1;
    tick();
    b1.init_req = 1'b0;
    chk("init_rd",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'd14});
    chk("init_rdy", 64'(b1.ready), 0);
    tick();
    b1.rd_en = 1'b0;
    chk("drop_v", 64'(b1.rd_valid), 0);
    chk("drop_hold", 64'(b1.rd_data), 14);
    chk("init_rd2",
        {b2.rd_valid, b2.rd_data},
        {1'b1, 32'd14});
    cnt = 1;
    while (!b1.ready && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("init_cycles", 64'(cnt), 16);
    rd(4'd7);
    chk("post_clr",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'h0});

`ifdef SRAM_PARITY_EN
    b1.par_inj = 1'b1;
    wr(4'd2, 32'h01020304, 4'hF);
    b1.par_inj = 1'b0;
    wr(4'd4, 32'h05060708, 4'hF);
    rd(4'd2);
    chk("perr_on",
        {b1.rd_valid, b1.par_err}, 2'b11);
    rd(4'd4);
    chk("perr_off",
        {b1.rd_valid, b1.par_err}, 2'b10);
`endif

    // Reset with reads outstanding
    wr(4'd9, 32'h5A5A5A5A, 4'hF);
    rd(4'd9);
    chk("mid_v",
        {b1.rd_valid, b1.rd_data},
        {1'b1, 32'h5A5A5A5A});
    rst = 1'b1;
    #1;
    chk("rst_v1", 64'(b1.rd_valid), 0);
    chk("rst_d1", 64'(b1.rd_data), 0);
    chk("rst_v2", 64'(b2.rd_valid), 0);
    tick();
    tick();
    chk("rst_v2b", 64'(b2.rd_valid), 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Parametrised successor to the team's single-port SRAM. It is a simple dual-port memory with one write port and one read port, usable in the same cycle.
- Per-byte write enables.
- Configurable registered read latency with a valid strobe.
- Hardware clear state machine that zeroes the array after reset or on request.
- Used as the scratch/buffer memory behind datapath blocks that need concurrent write and read.

Parameters:
ADDR, 4, address width in bits
DAT, 32, data width in bits; must be a multiple of 8
DEPTH, 16, number of words; must satisfy DEPTH <= 2**ADDR
RD_LAT, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error
BE_W, DAT/8, derived localparam: number of byte lanes

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
init_req  in  1  one-cycle pulse; re-runs the clear sweep
ready  out  1  high when read/write requests are accepted
wr_en  in  1  write request
wr_addr  in  ADDR  write address
wr_data  in  DAT  write data
wr_be  in  BE_W  byte enables; bit i covers data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR  read address
rd_data  out  DAT  read data; holds its value between reads
rd_valid  out  1  one-cycle strobe, one per accepted read

Behaviour:
- Reset (rst asserted, asynchronous):
  - state=ST_CLEAR, clr_ptr=0, ready=0, rd_valid=0, rd_data=0, read pipeline flushed.
  - Array contents are not reset directly.
- ST_CLEAR:
  - On each posedge, write mem[clr_ptr]=0 and increment clr_ptr.
  - The first posedge after rst deasserts clears address 0.
  - After the posedge that clears DEPTH-1: state→ST_RUN, ready=1. The sweep takes exactly DEPTH cycles.
- ST_RUN:
  - ready=1.
  - init_req=1 → ST_CLEAR, clr_ptr=0, ready=0 from the next cycle.
  - Reads already in the pipeline still complete and strobe rd_valid.
- Requests while ready=0 are silently dropped. No rd_valid is produced for them.
- Write (wr_en & ready):
  - At posedge, only the lanes with wr_be[i]=1 are updated.
  - wr_be=0 is a no-op.
  - wr_addr >= DEPTH: write is dropped.
- Read (rd_en & ready):
  - RD_LAT=1: rd_data=mem[rd_addr] and rd_valid=1 in the cycle after the request.
  - RD_LAT=2: same result, one cycle later.
  - Back-to-back reads give full throughput: one result per cycle.
  - rd_addr >= DEPTH: returns 0 with rd_valid=1.
- Same-cycle read and write to the same address: read-first. The read returns the pre-write contents.
- Write and read to different addresses in the same cycle: fully independent.
- rst asserted mid-read: rd_valid drops immediately and the outstanding result is discarded.
- init_req while in ST_CLEAR: restarts the sweep at clr_ptr=0.

Optional Feature:
SRAM_PARITY_EN
- When defined:
  - One even-parity bit is stored per byte lane; storage width is DAT+BE_W.
  - Added output par_err (1 bit): asserted together with rd_valid when any lane's recomputed parity mismatches. Reset value 0.
  - Added input par_inj (1 bit): when high during a write, inverts the stored parity of every written lane. Used for test only.
  - The clear sweep writes correct parity (0) for zeroed data.
- When undefined: no parity storage, and neither par_err nor par_inj exists.

Decomposition:
- Package sram_pkg contains:
  - State enum {ST_CLEAR, ST_RUN}.
  - Lane width constant (8).
  - Function even_par(byte).
- Sub-module sram_dp_array contains the storage with byte-lane write and a registered read port (one cycle).
- sram_dp_be contains the clear FSM, the request gating, the out-of-range checks, the extra pipeline stage when RD_LAT=2, and the parity logic.

Test Plan:
- Release rst, hold ready low, read all addresses once ready rises → ready rises exactly 16 cycles after release; all reads return 0 with one rd_valid each.
- Write 0xAABBCCDD to addr 3 with wr_be=4'hF, then write 0x11223344 with wr_be=4'b0101, then read addr 3 → 0xAA22CC44.
- Same cycle: write 0x12345678 to addr 5 (holding 0) and read addr 5; next cycle read addr 5 → first read returns 0, second returns 0x12345678.
- RD_LAT=2: 16 back-to-back reads of addr 0..15 after writing i*2 → rd_valid high for 16 consecutive cycles starting 2 cycles after the first read; data 0,2,...,30 in order.
- Fill memory, then pulse init_req with a read to addr 7 in flight → the in-flight read returns its stored value; ready is low for 16 cycles; a read of addr 7 issued during the clear is dropped; a subsequent read returns 0.
- SRAM_PARITY_EN: write addr 2 with par_inj=1, then read addr 2 → par_err=1 with rd_valid; read addr 4 (clean) → par_err=0.
